// File: rtl/mul_controller.sv
// Control FSM for the repeated-addition multiplier: loads A then B over the shared
// data_in bus, accumulates until B reaches zero, with abort and an iteration timeout.
module mul_controller #(
    parameter int unsigned W        = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         eqz,
    output logic         LdA,
    output logic         LdB,
    output logic         LdP,
    output logic         clrP,
    output logic         decB,
    output logic         op_sel,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLdA,
        StLdB,
        StAdd,
        StDone
    } state_e;

    localparam logic [W-1:0] MaxIter = W'(MAX_ITER);
    localparam logic [W-1:0] IterOne = W'(1);

    state_e         state_q, state_d;
    logic [W-1:0]   iter_cnt_q, iter_cnt_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        LdA        = 1'b0;
        LdB        = 1'b0;
        LdP        = 1'b0;
        clrP       = 1'b0;
        decB       = 1'b0;
        op_sel     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start && !abort) begin
                    state_d    = StLdA;
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            StLdA: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    LdA     = 1'b1;
                    state_d = StLdB;
                end
            end
            StLdB: begin
                op_sel = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    LdB     = 1'b1;
                    clrP    = 1'b1;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // Add strobes are Mealy on eqz so a zero multiplier performs no add.
                if (abort) begin
                    state_d = StIdle;
                end else if (eqz) begin
                    state_d = StDone;
                end else if (iter_cnt_q < MaxIter) begin
                    LdP        = 1'b1;
                    decB       = 1'b1;
                    iter_cnt_d = iter_cnt_q + IterOne;
                end else begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err      = err_q;
    assign iter_cnt = iter_cnt_q;

endmodule
